// File: rtl/fcmp_issue.sv
// Issue/retire stage feeding the single-precision feq/flt/fle compare cores through a small request FIFO.
// Optional NaN screening and invalid-flag generation are enabled by defining FCMP_NAN_EN.

module feq (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        y
);
    logic both_zero;
    assign both_zero = (a[30:23] == 8'h00) && (b[30:23] == 8'h00);
    assign y         = both_zero || (a == b);
endmodule

module flt (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        y
);
    logic both_zero;
    assign both_zero = (a[30:23] == 8'h00) && (b[30:23] == 8'h00);

    always_comb begin
        // NOTE: always_comb assigns a default first so no path leaves y unassigned (no latch).
        y = 1'b0;
        if (!both_zero) begin
            if (a[31] != b[31])
                y = a[31];
            else if (a[31])
                y = (b[30:0] < a[30:0]);
            else
                y = (a[30:0] < b[30:0]);
        end
    end
endmodule

module fle (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        y
);
    logic both_zero;
    logic lt;
    assign both_zero = (a[30:23] == 8'h00) && (b[30:23] == 8'h00);

    always_comb begin
        lt = 1'b0;
        if (a[31] != b[31])
            lt = a[31];
        else if (a[31])
            lt = (b[30:0] < a[30:0]);
        else
            lt = (a[30:0] < b[30:0]);
    end

    assign y = both_zero || (a == b) || lt;
endmodule

module fcmp_issue #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        OP_FEQ = 2'b00,
        OP_FLT = 2'b01,
        OP_FLE = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    logic [1:0]       op_mem  [DEPTH];
    logic [31:0]      x1_mem  [DEPTH];
    logic [31:0]      x2_mem  [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_y_q, out_y_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_nv_q, out_nv_d;

    logic             push;
    logic             load;
    logic [1:0]       head_op;
    logic [31:0]      head_x1;
    logic [31:0]      head_x2;
    logic [TAG_W-1:0] head_tag;
    logic             eq_y, lt_y, le_y;
    logic             core_res;
    logic             head_res;
    logic             head_nv;

    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign load     = (count_q != '0) && (!out_valid_q || out_ready);

    // NOTE: the storage array carries no reset; count and pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]  <= in_op;
            x1_mem[wr_ptr_q]  <= in_x1;
            x2_mem[wr_ptr_q]  <= in_x2;
            tag_mem[wr_ptr_q] <= in_tag;
        end
    end

    assign head_op  = op_mem[rd_ptr_q];
    assign head_x1  = x1_mem[rd_ptr_q];
    assign head_x2  = x2_mem[rd_ptr_q];
    assign head_tag = tag_mem[rd_ptr_q];

    feq u_feq (.a(head_x1), .b(head_x2), .y(eq_y));
    flt u_flt (.a(head_x1), .b(head_x2), .y(lt_y));
    fle u_fle (.a(head_x1), .b(head_x2), .y(le_y));

    always_comb begin
        core_res = 1'b0;
        case (op_e'(head_op))
            OP_FEQ:  core_res = eq_y;
            OP_FLT:  core_res = lt_y;
            OP_FLE:  core_res = le_y;
            default: core_res = 1'b0;
        endcase
    end

`ifdef FCMP_NAN_EN
    logic x1_nan, x2_nan, x1_snan, x2_snan;
    assign x1_nan  = (head_x1[30:23] == 8'hFF) && (head_x1[22:0] != 23'h0);
    assign x2_nan  = (head_x2[30:23] == 8'hFF) && (head_x2[22:0] != 23'h0);
    assign x1_snan = x1_nan && !head_x1[22];
    assign x2_snan = x2_nan && !head_x2[22];

    always_comb begin
        head_res = core_res && !(x1_nan || x2_nan);
        head_nv  = 1'b0;
        case (op_e'(head_op))
            OP_FEQ:         head_nv = x1_snan || x2_snan;
            OP_FLT, OP_FLE: head_nv = x1_nan || x2_nan;
            default:        head_nv = 1'b0;
        endcase
    end
`else
    assign head_res = core_res;
    assign head_nv  = 1'b0;
`endif

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_tag_d   = out_tag_q;
        out_nv_d    = out_nv_q;

        if (flush) begin
            // Result data stays put; only occupancy and the valid bit are cleared.
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (load)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(load);

            if (load) begin
                out_valid_d = 1'b1;
                out_y_d     = {31'b0, head_res};
                out_tag_d   = head_tag;
                out_nv_d    = head_nv;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_tag_q   <= '0;
            out_nv_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_tag_q   <= out_tag_d;
            out_nv_q    <= out_nv_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_tag   = out_tag_q;
    assign out_nv    = out_nv_q;

endmodule
